// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared types for the SDF stage sequencer. Rev 1.0
`default_nettype none

package fft_seq_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_BFLY, ST_DRAIN} seq_st_e;
  typedef enum logic {SEL_SUM, SEL_DIFF} dout_sel_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_sdf_stage_seq_dly.sv
// ctrl_dly_line: LAT-deep {valid, sel, done} delay line, sync clear, async reset. Rev 1.0
`default_nettype none

module ctrl_dly_line #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic in_valid,
  input  logic in_sel,
  input  logic in_done,
  output logic out_valid,
  output logic out_sel,
  output logic out_done
);

  generate
    if (LAT == 0) begin : g_bypass
      assign {out_valid, out_sel, out_done} = {in_valid, in_sel, in_done};
    end else begin : g_pipe
      logic [2:0] stg [LAT];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else begin
          stg[0] <= {in_valid, in_sel, in_done};
          for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
      end

      assign {out_valid, out_sel, out_done} = stg[LAT-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fft_sdf_stage_seq.sv
// fft_sdf_stage_seq: radix-2 SDF stage sequencer; FFT_SEQ_STAT_EN adds frame/stall counters. Rev 1.0
`default_nettype none

module fft_sdf_stage_seq
  import fft_seq_pkg::*;
#(
  parameter int N_BLK    = 32,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = $clog2(N_BLK)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             buf_wr_en,
  output logic             buf_rd_en,
  output logic             bf_en,
  output logic             tw_en,
  output logic [CNT_W-2:0] tw_idx,
  output logic             dout_valid,
  output logic             dout_sel,
  output logic             frame_done
`ifdef FFT_SEQ_STAT_EN
  ,
  output logic [STAT_W-1:0] frm_cnt,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] H_M1 = CNT_W'(N_BLK/2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BLK - 1);

  seq_st_e          state, state_nx;
  logic [CNT_W-1:0] blk, blk_nx;
  logic             accept;
  logic             iss_valid, iss_done;
  dout_sel_e        iss_sel;

  assign din_ready = (state != ST_DRAIN) && !flush;
  assign accept    = din_valid && din_ready;
  assign tw_idx    = tw_en ? blk[CNT_W-2:0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      blk   <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      blk   <= '0;
    end else begin
      state <= state_nx;
      blk   <= blk_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    blk_nx    = blk;
    buf_wr_en = 1'b0;
    buf_rd_en = 1'b0;
    bf_en     = 1'b0;
    tw_en     = 1'b0;
    iss_valid = 1'b0;
    iss_sel   = SEL_SUM;
    iss_done  = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        buf_wr_en = 1'b1;
        blk_nx    = CNT_W'(1);
        state_nx  = ST_FILL;
      end
      ST_FILL: if (accept) begin
        buf_wr_en = 1'b1;
        blk_nx    = blk + 1'b1;
        if (blk == H_M1) state_nx = ST_BFLY;
      end
      ST_BFLY: if (accept) begin
        // Current block pairs with the buffered one; the difference goes back into the buffer.
        bf_en     = 1'b1;
        buf_rd_en = 1'b1;
        buf_wr_en = 1'b1;
        iss_valid = 1'b1;
        blk_nx    = blk + 1'b1;
        if (blk == LAST) begin
          state_nx = ST_DRAIN;
          blk_nx   = '0;
        end
      end
      ST_DRAIN: if (!flush) begin
        buf_rd_en = 1'b1;
        tw_en     = 1'b1;
        iss_valid = 1'b1;
        iss_sel   = SEL_DIFF;
        blk_nx    = blk + 1'b1;
        if (blk == H_M1) begin
          iss_done = 1'b1;
          state_nx = ST_IDLE;
          blk_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        blk_nx   = '0;
      end
    endcase
  end

  ctrl_dly_line #(.LAT(PIPE_LAT)) u_dly (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (flush),
    .in_valid (iss_valid),
    .in_sel   (iss_sel),
    .in_done  (iss_done),
    .out_valid(dout_valid),
    .out_sel  (dout_sel),
    .out_done (frame_done)
  );

`ifdef FFT_SEQ_STAT_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frm_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (frame_done) frm_cnt <= sat_inc(frm_cnt);
      if ((state == ST_FILL || state == ST_BFLY) && !din_valid)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_sdf_stage_seq.sv
// tb_fft_sdf_stage_seq: directed self-checking bench (N_BLK=32/PIPE_LAT=2 plus N_BLK=4/PIPE_LAT=0).
`default_nettype none

module tb_fft_sdf_stage_seq;

  localparam int N = 32;
  localparam int H = 16;

  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0, din_valid = 1'b0;
  logic din_ready, buf_wr_en, buf_rd_en, bf_en, tw_en, dout_valid, dout_sel, frame_done;
  logic [3:0] tw_idx;
`ifdef FFT_SEQ_STAT_EN
  logic [15:0] frm_cnt, stall_cnt;
`endif

  logic flush2 = 1'b0, din_valid2 = 1'b0;
  logic din_ready2, buf_wr_en2, buf_rd_en2, bf_en2, tw_en2, dout_valid2, dout_sel2, frame_done2;
  logic [0:0] tw_idx2;
`ifdef FFT_SEQ_STAT_EN
  logic [15:0] frm_cnt2, stall_cnt2;
`endif

  fft_sdf_stage_seq #(.N_BLK(N), .PIPE_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .din_valid(din_valid), .din_ready(din_ready),
    .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en), .bf_en(bf_en), .tw_en(tw_en),
    .tw_idx(tw_idx), .dout_valid(dout_valid), .dout_sel(dout_sel), .frame_done(frame_done)
`ifdef FFT_SEQ_STAT_EN
    , .frm_cnt(frm_cnt), .stall_cnt(stall_cnt)
`endif
  );

  fft_sdf_stage_seq #(.N_BLK(4), .PIPE_LAT(0)) dut2 (
    .clk(clk), .rstn(rstn), .flush(flush2), .din_valid(din_valid2), .din_ready(din_ready2),
    .buf_wr_en(buf_wr_en2), .buf_rd_en(buf_rd_en2), .bf_en(bf_en2), .tw_en(tw_en2),
    .tw_idx(tw_idx2), .dout_valid(dout_valid2), .dout_sel(dout_sel2), .frame_done(frame_done2)
`ifdef FFT_SEQ_STAT_EN
    , .frm_cnt(frm_cnt2), .stall_cnt(stall_cnt2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int n_acc, n_bf, bf_bad, n_sum, n_diff, n_done, done_bad, ord_bad, tw_bad, tw_exp;
  int n_rdy_low, gap_bad, b2b_ok, first_lat, acc16_cyc, prev_rdy_low;
  int s_sum, s_diff, s_done, s_coin_bad, s_tw_bad, s_tw_exp;

  task automatic clr_counts();
    n_acc = 0; n_bf = 0; bf_bad = 0; n_sum = 0; n_diff = 0; n_done = 0; done_bad = 0;
    ord_bad = 0; tw_bad = 0; tw_exp = 0; n_rdy_low = 0; gap_bad = 0; b2b_ok = 0;
    first_lat = -1; acc16_cyc = -1; prev_rdy_low = 0;
  endtask

  task automatic tick(input logic v, input logic f);
    logic acc;
    int idx;
    din_valid = v;
    flush     = f;
    @(negedge clk);
    acc = din_valid && din_ready;
    if (acc) begin
      idx = n_acc % N;
      if (bf_en !== (idx >= H) || !buf_wr_en || buf_rd_en !== (idx >= H)) bf_bad++;
      if (idx == H) acc16_cyc = cyc;
      if (prev_rdy_low != 0) b2b_ok++;
      n_acc++;
    end
    if (bf_en) n_bf++;
    if (!acc && din_ready && (buf_wr_en || buf_rd_en || bf_en || tw_en)) gap_bad++;
    if (!din_ready) n_rdy_low++;
    if (tw_en) begin
      if (int'(tw_idx) != tw_exp) tw_bad++;
      tw_exp = (tw_exp + 1) % H;
    end
    if (dout_valid) begin
      if (dout_sel) begin
        if (n_sum % H != 0) ord_bad++;
        n_diff++;
      end else begin
        n_sum++;
        if (first_lat < 0 && acc16_cyc >= 0) first_lat = cyc - acc16_cyc;
      end
    end
    if (frame_done) begin
      n_done++;
      if (!(dout_valid && dout_sel && (n_diff % H == 0))) done_bad++;
    end
    prev_rdy_low = din_ready ? 0 : 1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick2(input logic v);
    din_valid2 = v;
    @(negedge clk);
    if (dout_valid2 !== (bf_en2 | tw_en2)) s_coin_bad++;
    if (dout_valid2 && (dout_sel2 !== tw_en2)) s_coin_bad++;
    if (tw_en2) begin
      if (int'(tw_idx2) != s_tw_exp) s_tw_bad++;
      s_tw_exp++;
    end
    if (dout_valid2 && !dout_sel2) s_sum++;
    if (dout_valid2 && dout_sel2) s_diff++;
    if (frame_done2) s_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; din_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic run_frame(input int gap_a, input int gap_b);
    for (int b = 0; b < N; b++) begin
      if (b == gap_a || b == gap_b) repeat (3) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
    end
    repeat (H + 4) tick(1'b0, 1'b0);
  endtask

  initial begin
    // 1: reset state, then one contiguous frame
    @(negedge clk);
    check("rst_din_ready", din_ready, 1);
    check("rst_strobes", {buf_wr_en, buf_rd_en, bf_en, tw_en}, 0);
    check("rst_dout", {dout_valid, frame_done}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    clr_counts();
    run_frame(-1, -1);
    check("t1_accepts", n_acc, 32);
    check("t1_bf_count", n_bf, 16);
    check("t1_bf_pattern", bf_bad, 0);
    check("t1_first_lat", first_lat, 2);
    check("t1_sums", n_sum, 16);
    check("t1_diffs", n_diff, 16);
    check("t1_order", ord_bad, 0);
    check("t1_tw_seq", tw_bad, 0);
    check("t1_done", n_done, 1);
    check("t1_done_align", done_bad, 0);
    check("t1_rdy_low", n_rdy_low, 16);

    // 2: gaps at blocks 8 and 20
    do_reset();
    clr_counts();
    run_frame(8, 20);
    check("t2_gap_strobes", gap_bad, 0);
    check("t2_sums", n_sum, 16);
    check("t2_diffs", n_diff, 16);
    check("t2_bf_pattern", bf_bad, 0);
`ifdef FFT_SEQ_STAT_EN
    check("t2_stall_cnt", stall_cnt, 6);
`endif

    // 3: two frames, din_valid held high
    do_reset();
    clr_counts();
    repeat (2 * (N + H)) tick(1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    check("t3_accepts", n_acc, 64);
    check("t3_b2b", b2b_ok, 1);
    check("t3_done", n_done, 2);
    check("t3_sums", n_sum, 32);
    check("t3_diffs", n_diff, 32);
`ifdef FFT_SEQ_STAT_EN
    check("t3_frm_cnt", frm_cnt, 2);
`endif

    // 4: flush at block 20
    do_reset();
    clr_counts();
    repeat (20) tick(1'b1, 1'b0);
    din_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("t4_flush_rdy", din_ready, 0);
    check("t4_flush_strobes", {buf_wr_en, buf_rd_en, bf_en}, 0);
    @(posedge clk); #1;
    din_valid = 1'b0; flush = 1'b0;
    #1;
    check("t4_idle_rdy", din_ready, 1);
    clr_counts();
    repeat (6) tick(1'b0, 1'b0);
    check("t4_no_dout", n_sum + n_diff + n_done, 0);
    clr_counts();
    run_frame(-1, -1);
    check("t4_clean_sums", n_sum, 16);
    check("t4_clean_diffs", n_diff, 16);
    check("t4_clean_done", n_done, 1);
`ifdef FFT_SEQ_STAT_EN
    check("t4_frm_cnt", frm_cnt, 1);
`endif

    // 5: async reset mid-DRAIN at k=5
    clr_counts();
    repeat (N) tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    check("t5_k5", {tw_en, tw_idx}, {1'b1, 4'd5});
    rstn = 1'b0;
    #1;
    check("t5_rst_rdy", din_ready, 1);
    check("t5_rst_strobes", {buf_wr_en, buf_rd_en, bf_en, tw_en, tw_idx}, 0);
    check("t5_rst_dout", {dout_valid, dout_sel, frame_done}, 0);
`ifdef FFT_SEQ_STAT_EN
    check("t5_frm_cnt", frm_cnt, 0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;

    // 6: N_BLK=4, PIPE_LAT=0 instance
    s_sum = 0; s_diff = 0; s_done = 0; s_coin_bad = 0; s_tw_bad = 0; s_tw_exp = 0;
    repeat (4) tick2(1'b1);
    repeat (4) tick2(1'b0);
    check("t6_coincident", s_coin_bad, 0);
    check("t6_sums", s_sum, 2);
    check("t6_diffs", s_diff, 2);
    check("t6_tw_seq", s_tw_bad, 0);
    check("t6_tw_count", s_tw_exp, 2);
    check("t6_done", s_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
